// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer: state encoding,
// injected-push opcodes and the condition-code width.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        PUSH_PCH = 3'd2,
        PUSH_PCL = 3'd3,
        PUSH_CCR = 3'd4,
        VECTOR   = 3'd5,
        ISR      = 3'd6
    } seq_state_e;

    localparam logic [1:0] INJ_NONE = 2'b00;
    localparam logic [1:0] INJ_PCH  = 2'b01;
    localparam logic [1:0] INJ_PCL  = 2'b10;
    localparam logic [1:0] INJ_CCR  = 2'b11;

    localparam int CCR_W = 3;

    // Zero-extend the saved flags into a 16-bit stack word.
    function automatic logic [15:0] ccr_word(input logic [CCR_W-1:0] c);
        return {{(16-CCR_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Signal bundle between the interrupt sequencer (master) and the pipeline
// (slave): request/hazard inputs, push injection and PC redirect outputs.
interface interrupt_sequencer_if;
    import interrupt_sequencer_pkg::*;

    logic             interrupt;
    logic [31:0]      ret_pc;
    logic [CCR_W-1:0] ccr;
    logic             pipe_busy;
    logic             stall;
    logic             inject_ready;
    logic             rti_done;
    logic             fetch_freeze;
    logic             inject_valid;
    logic [1:0]       inject_op;
    logic [15:0]      push_data;
    logic             pc_load;
    logic [31:0]      pc_load_value;
    logic             ack;
    logic             in_isr;

    modport master (
        input  interrupt, ret_pc, ccr, pipe_busy, stall, inject_ready, rti_done,
        output fetch_freeze, inject_valid, inject_op, push_data,
               pc_load, pc_load_value, ack, in_isr
    );

    modport slave (
        output interrupt, ret_pc, ccr, pipe_busy, stall, inject_ready, rti_done,
        input  fetch_freeze, inject_valid, inject_op, push_data,
               pc_load, pc_load_value, ack, in_isr
    );

endinterface

// File: rtl/interrupt_sequencer_edge.sv
// Rising-edge detector on the interrupt line with a sticky pending flag.
// Several edges before the flag is consumed collapse into one request.
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic clr_i,
    output logic pending_o
);

    logic int_q;
    logic pend_q;
    logic pend_d;

    // A fresh edge wins over a clear arriving in the same cycle.
    always_comb begin
        pend_d = (irq_i & ~int_q) | (pend_q & ~clr_i);
    end

    // Line history and pending flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            int_q  <= irq_i;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: waits for a safe slot, freezes fetch, drains the
// pipe, injects PC-high / PC-low / CCR pushes, redirects to the vector and
// blocks nesting until RTI completes. All outputs are registered.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    interrupt_sequencer_if.master bus
);

    seq_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      saved_pc_q, saved_pc_d;
    logic [CCR_W-1:0] saved_ccr_q, saved_ccr_d;
    logic             pending;
    logic             pend_clr;

    logic        freeze_q, freeze_d;
    logic        valid_q, valid_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] data_q, data_d;
    logic        pcl_q, pcl_d;
    logic [31:0] pcv_q, pcv_d;
    logic        ack_q, ack_d;
    logic        isr_q, isr_d;

    int_edge_latch u_edge (
        .clk       (clk),
        .rst       (rst),
        .irq_i     (bus.interrupt),
        .clr_i     (pend_clr),
        .pending_o (pending)
    );

    // Next-state logic: slot acceptance, drain countdown, push handshakes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        saved_pc_d  = saved_pc_q;
        saved_ccr_d = saved_ccr_q;
        pend_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending && !bus.pipe_busy && !bus.stall) begin
                    state_d     = DRAIN;
                    cnt_d       = 4'(DRAIN_CYCLES - 1);
                    saved_pc_d  = bus.ret_pc;
                    saved_ccr_d = bus.ccr;
                    pend_clr    = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) state_d = PUSH_PCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            PUSH_PCH: if (bus.inject_ready) state_d = PUSH_PCL;
            PUSH_PCL: if (bus.inject_ready) state_d = PUSH_CCR;
            PUSH_CCR: if (bus.inject_ready) state_d = VECTOR;
            VECTOR:   state_d = ISR;
            ISR:      if (bus.rti_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        freeze_d = 1'b0;
        valid_d  = 1'b0;
        op_d     = INJ_NONE;
        data_d   = 16'h0000;
        pcl_d    = 1'b0;
        pcv_d    = VECTOR_ADDR;
        ack_d    = 1'b0;
        isr_d    = 1'b0;
        case (state_d)
            DRAIN: freeze_d = 1'b1;
            PUSH_PCH: begin
                freeze_d = 1'b1;
                valid_d  = 1'b1;
                op_d     = INJ_PCH;
                data_d   = saved_pc_d[31:16];
            end
            PUSH_PCL: begin
                freeze_d = 1'b1;
                valid_d  = 1'b1;
                op_d     = INJ_PCL;
                data_d   = saved_pc_d[15:0];
            end
            PUSH_CCR: begin
                freeze_d = 1'b1;
                valid_d  = 1'b1;
                op_d     = INJ_CCR;
                data_d   = ccr_word(saved_ccr_d);
            end
            VECTOR: begin
                pcl_d = 1'b1;
                ack_d = 1'b1;
                isr_d = 1'b1;
            end
            ISR:     isr_d = 1'b1;
            default: ;
        endcase
    end

    // State, saved context and output registers; reset abandons any sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            saved_pc_q  <= 32'h0;
            saved_ccr_q <= '0;
            freeze_q    <= 1'b0;
            valid_q     <= 1'b0;
            op_q        <= INJ_NONE;
            data_q      <= 16'h0000;
            pcl_q       <= 1'b0;
            pcv_q       <= 32'h0;
            ack_q       <= 1'b0;
            isr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            saved_pc_q  <= saved_pc_d;
            saved_ccr_q <= saved_ccr_d;
            freeze_q    <= freeze_d;
            valid_q     <= valid_d;
            op_q        <= op_d;
            data_q      <= data_d;
            pcl_q       <= pcl_d;
            pcv_q       <= pcv_d;
            ack_q       <= ack_d;
            isr_q       <= isr_d;
        end
    end

    assign bus.fetch_freeze  = freeze_q;
    assign bus.inject_valid  = valid_q;
    assign bus.inject_op     = op_q;
    assign bus.push_data     = data_q;
    assign bus.pc_load       = pcl_q;
    assign bus.pc_load_value = pcv_q;
    assign bus.ack           = ack_q;
    assign bus.in_isr        = isr_q;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Controller that sequences interrupt entry for the 5-stage pipeline.
- Detects a rising edge on the external interrupt line and waits for a safe slot (no control transfer in flight, no load-use stall).
- Freezes fetch, drains in-flight instructions, then injects three stack pushes into the memory stage: PC high, PC low, CCR.
- Redirects the PC to the ISR vector, pulses ack, and blocks nesting until RTI completes.

Parameters:
VECTOR_ADDR, 32'h0000_0000, PC value loaded on interrupt entry
DRAIN_CYCLES, 3, cycles fetch is frozen before the first push (pipeline depth behind decode); legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
interrupt  in  1  external interrupt request, synchronous to clk, edge-triggered
ret_pc  in  32  PC of next instruction to resume; sampled on slot acceptance
ccr  in  3  current condition flags {C,N,Z}; sampled on slot acceptance
pipe_busy  in  1  branch/call/ret/rti in flight or flush active
stall  in  1  load-use hazard freeze active
inject_ready  in  1  memory stage accepts an injected push this cycle
rti_done  in  1  one-cycle pulse when RTI has finished popping CCR/PC
fetch_freeze  out  1  hold PC and insert bubbles into IF/ID
inject_valid  out  1  push request valid
inject_op  out  2  00 none, 01 PC high, 10 PC low, 11 CCR
push_data  out  16  data for the current push
pc_load  out  1  one-cycle PC overwrite strobe
pc_load_value  out  32  value loaded into the PC
ack  out  1  one-cycle interrupt acknowledge
in_isr  out  1  high from VECTOR until rti_done

Behaviour:
- All outputs are registered (Moore). Reset (rst=0, async) forces state IDLE and clears pending, saved_pc, saved_ccr, drain counter, and every output to 0. A reset mid-sequence abandons the sequence with no partial push completed afterwards.
- Edge detect: int_q samples interrupt each cycle. Condition interrupt & ~int_q sets pending at that edge. pending clears only on the IDLE->DRAIN transition. Multiple edges while pending collapse into one request.
- IDLE: when pending & ~pipe_busy & ~stall, latch saved_pc=ret_pc and saved_ccr=ccr, load cnt=DRAIN_CYCLES-1, go to DRAIN. fetch_freeze rises with the state change.
- DRAIN: fetch_freeze=1. cnt decrements each cycle. When cnt==0, go to PUSH_PCH. stall/pipe_busy are ignored here.
- PUSH_PCH / PUSH_PCL / PUSH_CCR: fetch_freeze=1, inject_valid=1.
  - inject_op is 01/10/11 respectively.
  - push_data is saved_pc[31:16], saved_pc[15:0], and {13'b0, saved_ccr} respectively.
  - Valid and data are held stable until the cycle inject_ready=1, then advance to the next state.
  - The push order is fixed so RTI pops in the order CCR, PCL, PCH.
- VECTOR (exactly 1 cycle):
  - Outputs: pc_load=1, pc_load_value=VECTOR_ADDR, ack=1, in_isr=1, fetch_freeze=0, inject_valid=0.
  - Next state is ISR.
- ISR: in_isr=1, all other outputs 0. rti_done returns to IDLE.
  - Interrupt edges arriving in ISR set pending and are serviced after return (no nesting).
  - rti_done in any state other than ISR is ignored.
- Simultaneous events:
  - rti_done with a pending request: go to IDLE first, then evaluate pending on the next cycle.
  - An interrupt edge on the same cycle as the IDLE->DRAIN transition re-sets pending.
- Latency:
  - Edge sampled at clock k sets pending.
  - DRAIN is entered at k+1 if unblocked.
  - First inject_valid appears at k+1+DRAIN_CYCLES.
  - With inject_ready held high, ack appears at k+4+DRAIN_CYCLES.
- pc_load_value holds VECTOR_ADDR when pc_load=0 (don't-care for consumers).

Decomposition:
- Shared package for the processor:
  - state enum (IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_CCR, VECTOR, ISR; 3-bit encoding);
  - inject_op constants INJ_NONE/INJ_PCH/INJ_PCL/INJ_CCR;
  - CCR width constant (3).
- One natural sub-module: int_edge_latch (edge detect plus sticky pending with a clear input). Everything else stays flat.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, interrupt toggling -> all outputs 0. Release rst, no interrupt for 10 cycles -> state IDLE, outputs 0.
2. Basic entry: DRAIN_CYCLES=3, ret_pc=32'h0001_0A2C, ccr=3'b101, inject_ready=1.
   - Interrupt edge at cycle 5 -> fetch_freeze from cycle 6.
   - Pushes 0x0001, 0x0A2C, 0x0005 with ops 01/10/11 on cycles 9/10/11.
   - Cycle 12: pc_load=1, pc_load_value=0, ack=1. in_isr stays 1 until rti_done.
3. Blocked slot: pending with pipe_busy=1 for 4 cycles then stall=1 for 2 -> stays IDLE with fetch_freeze=0. Enters DRAIN on the first cycle both are low, capturing ret_pc from that cycle.
4. Backpressure: inject_ready=0 for 3 cycles during PUSH_PCL -> inject_op=10 and push_data=saved_pc[15:0] held stable. Advances one cycle after ready=1, no duplicate push.
5. No nesting: edge during ISR -> no freeze or push. After rti_done, full entry sequence replays with new ret_pc. A second edge in the same ISR produces only one extra entry.
6. Reset mid-push: rst=0 asynchronously while in PUSH_PCH -> inject_valid and fetch_freeze drop immediately, pending cleared. After release, no sequence resumes without a new edge.
